// File: rtl/alu_seq_pkg.sv
// Shared types and ALU select codes for the wide ALU sequencer.
// Op encodings, FSM states and the per-byte select helper live here.
package alu_seq_pkg;

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_ADDC = 4'd1;
    localparam logic [3:0] SEL_SUB  = 4'd2;
    localparam logic [3:0] SEL_SUBC = 4'd3;
    localparam logic [3:0] SEL_AND  = 4'd5;
    localparam logic [3:0] SEL_OR   = 4'd6;
    localparam logic [3:0] SEL_XOR  = 4'd7;
    localparam logic [3:0] SEL_LSL  = 4'd9;
    localparam logic [3:0] SEL_LSR  = 4'd10;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_LSL  = 3'd5,
        OP_LSR  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Control bits captured when a request is accepted.
    typedef struct packed {
        op_t  op;
        logic cin_en;
        logic cin;
    } ctl_t;

    // ALU select for one byte slot; only the first ADD/SUB byte
    // may skip the carry-in variant.
    function automatic logic [3:0] byte_sel(
        input op_t  op,
        input logic first,
        input logic cin_en
    );
        logic [3:0] sel;
        sel = SEL_ADD;
        unique case (op)
            OP_ADD:  sel = (first && !cin_en) ? SEL_ADD : SEL_ADDC;
            OP_SUB:  sel = (first && !cin_en) ? SEL_SUB : SEL_SUBC;
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            OP_XOR:  sel = SEL_XOR;
            OP_LSL:  sel = SEL_LSL;
            OP_LSR:  sel = SEL_LSR;
            default: sel = SEL_ADD;
        endcase
        return sel;
    endfunction

    // Carry-in for one byte slot given latched control and the
    // carry chained from the previous byte.
    function automatic logic byte_cin(
        input ctl_t ctl,
        input logic first,
        input logic carry
    );
        logic cin;
        cin = 1'b0;
        unique case (ctl.op)
            OP_ADD, OP_SUB: cin = first ? (ctl.cin_en & ctl.cin) : carry;
            OP_LSL, OP_LSR: cin = first ? ctl.cin : carry;
            default:        cin = 1'b0;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// Drives an external 8-bit ALU one byte per cycle to build a
// W-bit result with chained carry and aggregate zero flag.
module alu_wide_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [2:0]   OP,
    input  logic         CIN_EN,
    input  logic         CIN,
    input  logic [W-1:0] A_W,
    input  logic [W-1:0] B_W,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] RESULT,
    output logic         C,
    output logic         Z,
    output logic [3:0]   ALU_SEL,
    output logic [7:0]   ALU_A,
    output logic [7:0]   ALU_B,
    output logic         ALU_CIN,
    input  logic [7:0]   ALU_RESULT,
    input  logic         ALU_C,
    input  logic         ALU_Z
);

    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    state_t         state_q;
    state_t         state_d;
    ctl_t           ctl_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic           zacc_q;
    logic           c_q;
    logic           z_q;

    op_t            op_in;
    logic           accept;
    logic           is_lsr;
    logic           first_byte;
    logic           last_byte;
    logic [IW+2:0]  bit_base;

    assign op_in  = op_t'(OP);
    assign accept = START && (op_in != OP_RSVD) && (state_q != ST_RUN);

    // LSR walks from the top byte down so the shift-in bit enters at the MSB.
    assign is_lsr     = (ctl_q.op == OP_LSR);
    assign first_byte = is_lsr ? (idx_q == IDX_LAST) : (idx_q == '0);
    assign last_byte  = is_lsr ? (idx_q == '0) : (idx_q == IDX_LAST);
    assign bit_base   = {idx_q, 3'b000};

    assign RESULT = res_q;
    assign C      = c_q;
    assign Z      = z_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DONE lasts one cycle unless a new request chains.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = accept ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = last_byte ? ST_DONE : ST_RUN;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: ALU drive is forced to zero outside RUN.
    always_comb begin
        BUSY    = (state_q == ST_RUN);
        DONE    = (state_q == ST_DONE);
        ALU_SEL = 4'd0;
        ALU_A   = 8'd0;
        ALU_B   = 8'd0;
        ALU_CIN = 1'b0;
        if (state_q == ST_RUN) begin
            ALU_SEL = byte_sel(ctl_q.op, first_byte, ctl_q.cin_en);
            ALU_A   = a_q[bit_base +: 8];
            ALU_B   = b_q[bit_base +: 8];
            ALU_CIN = byte_cin(ctl_q, first_byte, carry_q);
        end
    end

    // Datapath: latch request, then collect one ALU byte per RUN cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctl_q   <= '{op: OP_ADD, cin_en: 1'b0, cin: 1'b0};
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            ctl_q   <= '{op: op_in, cin_en: CIN_EN, cin: CIN};
            a_q     <= A_W;
            b_q     <= B_W;
            idx_q   <= (op_in == OP_LSR) ? IDX_LAST : '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b1;
        end else if (state_q == ST_RUN) begin
            res_q[bit_base +: 8] <= ALU_RESULT;
            carry_q <= ALU_C;
            zacc_q  <= zacc_q & ALU_Z;
            if (last_byte) begin
                c_q <= ALU_C;
                z_q <= zacc_q & ALU_Z;
            end else if (is_lsr) begin
                idx_q <= idx_q - 1'b1;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer with a behavioural 8-bit ALU beside it.
// Table-driven vectors plus sequences for reset, reserved op and chaining.
module tb_alu_wide_sequencer;
    import alu_seq_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic         cin_en;
    logic         cin;
    logic [W-1:0] a_w;
    logic [W-1:0] b_w;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         z_out;
    logic [3:0]   alu_sel;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_cin;
    logic [7:0]   alu_res;
    logic         alu_c;
    logic         alu_z;

    alu_wide_sequencer #(.NBYTES(NB)) dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .OP         (op),
        .CIN_EN     (cin_en),
        .CIN        (cin),
        .A_W        (a_w),
        .B_W        (b_w),
        .BUSY       (busy),
        .DONE       (done),
        .RESULT     (result),
        .C          (c_out),
        .Z          (z_out),
        .ALU_SEL    (alu_sel),
        .ALU_A      (alu_a),
        .ALU_B      (alu_b),
        .ALU_CIN    (alu_cin),
        .ALU_RESULT (alu_res),
        .ALU_C      (alu_c),
        .ALU_Z      (alu_z)
    );

    // Reference 8-bit ALU: C is carry for adds, borrow for subs,
    // shifted-out bit for shifts, 0 for logic ops.
    always_comb begin
        logic [8:0] t;
        t       = 9'd0;
        alu_res = 8'd0;
        alu_c   = 1'b0;
        case (alu_sel)
            4'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            4'd2: t = {1'b0, alu_a} - {1'b0, alu_b};
            4'd3: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
            4'd5: t = {1'b0, alu_a & alu_b};
            4'd6: t = {1'b0, alu_a | alu_b};
            4'd7: t = {1'b0, alu_a ^ alu_b};
            4'd9: t = {alu_a[7], alu_a[6:0], alu_cin};
            4'd10: t = {alu_a[0], alu_cin, alu_a[7:1]};
            default: t = 9'd0;
        endcase
        alu_res = t[7:0];
        alu_c   = t[8];
        alu_z   = (t[7:0] == 8'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        cin_en;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic [15:0] sel;
        logic [31:0] aseq;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tv[12];
    vec_t vp;
    vec_t vb1;
    vec_t vb2;
    vec_t vr;

    function automatic vec_t mk(
        input string nm, input logic [2:0] o, input logic ce, input logic ci,
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
        input logic cc, input logic zz, input logic [15:0] s,
        input logic [31:0] aq
    );
        vec_t v;
        v.name = nm; v.op = o; v.cin_en = ce; v.cin = ci;
        v.a = a; v.b = b; v.res = r; v.c = cc; v.z = zz;
        v.sel = s; v.aseq = aq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; START is seen by the next posedge.
    task automatic launch(input vec_t v);
        op     = v.op;
        cin_en = v.cin_en;
        cin    = v.cin;
        a_w    = v.a;
        b_w    = v.b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Watches negedges until DONE; optionally pokes START mid-run.
    task automatic collect(input vec_t v, input int poke);
        int          n;
        int          nbusy;
        logic        got;
        logic [15:0] sq;
        logic [31:0] aq;
        n = 0; nbusy = 0; got = 1'b0; sq = '0; aq = '0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == poke) begin
                start = 1'b1;
                op    = OP_SUB;
                a_w   = 32'hDEADBEEF;
                b_w   = 32'h0BADF00D;
            end else if (n == poke + 1) begin
                start = 1'b0;
            end
            if (busy) begin
                nbusy++;
                sq = {sq[11:0], alu_sel};
                aq = {aq[23:0], alu_a};
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no DONE want DONE", v.name);
        end else begin
            chk({v.name, ".latency"}, n, 5);
        end
        chk({v.name, ".busy_cycles"}, nbusy, NB);
        chk({v.name, ".sel_seq"}, {16'd0, sq}, {16'd0, v.sel});
        chk({v.name, ".a_seq"}, aq, v.aseq);
        chk({v.name, ".result"}, result, v.res);
        chk({v.name, ".c"}, {31'd0, c_out}, {31'd0, v.c});
        chk({v.name, ".z"}, {31'd0, z_out}, {31'd0, v.z});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic act;

        tv[0]  = mk("add_ripple", OP_ADD, 0, 0, 32'h00FFFFFF, 32'h1,
                    32'h01000000, 0, 0, 16'h0111, 32'hFFFFFF00);
        tv[1]  = mk("add_wrap", OP_ADD, 0, 0, 32'hFFFFFFFF, 32'h1,
                    32'h0, 1, 1, 16'h0111, 32'hFFFFFFFF);
        tv[2]  = mk("sub_under", OP_SUB, 0, 0, 32'h0, 32'h1,
                    32'hFFFFFFFF, 1, 0, 16'h2333, 32'h0);
        tv[3]  = mk("sub_cin", OP_SUB, 1, 1, 32'h5, 32'h4,
                    32'h0, 0, 1, 16'h3333, 32'h05000000);
        tv[4]  = mk("lsl", OP_LSL, 0, 1, 32'h80000001, 32'h0,
                    32'h3, 1, 0, 16'h9999, 32'h01000080);
        tv[5]  = mk("lsr", OP_LSR, 0, 0, 32'h80000001, 32'h0,
                    32'h40000000, 1, 0, 16'hAAAA, 32'h80000001);
        tv[6]  = mk("xor_self", OP_XOR, 0, 0, 32'h12345678, 32'h12345678,
                    32'h0, 0, 1, 16'h7777, 32'h78563412);
        tv[7]  = mk("and", OP_AND, 0, 0, 32'hF0F0F0F0, 32'h0FF0FF00,
                    32'h00F0F000, 0, 0, 16'h5555, 32'hF0F0F0F0);
        tv[8]  = mk("or", OP_OR, 0, 0, 32'h12000034, 32'h00560000,
                    32'h12560034, 0, 0, 16'h6666, 32'h34000012);
        tv[9]  = mk("add_cin", OP_ADD, 1, 1, 32'h7FFFFFFF, 32'h0,
                    32'h80000000, 0, 0, 16'h1111, 32'hFFFFFF7F);
        tv[10] = mk("sub_pos", OP_SUB, 0, 0, 32'hA, 32'h5,
                    32'h5, 0, 0, 16'h2333, 32'h0A000000);
        tv[11] = mk("lsr_cin", OP_LSR, 0, 1, 32'h0, 32'h0,
                    32'h80000000, 0, 0, 16'hAAAA, 32'h0);

        vp  = mk("busy_poke", OP_ADD, 0, 0, 32'h1, 32'h2,
                 32'h3, 0, 0, 16'h0111, 32'h01000000);
        vb1 = mk("b2b_first", OP_SUB, 0, 0, 32'hA, 32'h5,
                 32'h5, 0, 0, 16'h2333, 32'h0A000000);
        vb2 = mk("b2b_second", OP_LSL, 0, 1, 32'h80000001, 32'h0,
                 32'h3, 1, 0, 16'h9999, 32'h01000080);
        vr  = mk("rst_run", OP_ADD, 0, 0, 32'h01010101, 32'h01010101,
                 32'h02020202, 0, 0, 16'h0111, 32'h01010101);

        rst = 1'b1; start = 1'b0; op = '0; cin_en = 1'b0; cin = 1'b0;
        a_w = '0; b_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.c", {31'd0, c_out}, 32'd0);
        chk("rst.z", {31'd0, z_out}, 32'd0);
        chk("rst.alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("rst.alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst.alu_b", {24'd0, alu_b}, 32'd0);
        chk("rst.alu_cin", {31'd0, alu_cin}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            launch(tv[i]);
            collect(tv[i], 0);
        end

        @(negedge clk);
        op = 3'd7; a_w = 32'h11111111; b_w = 32'h22222222;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        act = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done || alu_sel != 4'd0) act = 1'b1;
        end
        chk("rsvd.no_activity", {31'd0, act}, 32'd0);
        chk("rsvd.result_held", result, tv[11].res);

        @(negedge clk);
        launch(vp);
        collect(vp, 2);

        @(negedge clk);
        launch(vb1);
        collect(vb1, 0);
        launch(vb2);
        collect(vb2, 0);

        @(negedge clk);
        launch(vr);
        repeat (3) @(negedge clk);
        chk("rst_run.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_run.busy", {31'd0, busy}, 32'd0);
        chk("rst_run.result", result, 32'd0);
        chk("rst_run.done", {31'd0, done}, 32'd0);
        chk("rst_run.alu_a", {24'd0, alu_a}, 32'd0);
        act = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) act = 1'b1;
        end
        chk("rst_run.no_done", {31'd0, act}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
- Multi-cycle initiator that drives the team's 8-bit ALU port set (SEL/A/B/CIN out, RESULT/C/Z in) to perform W = 8*NBYTES-bit operations one byte per cycle.
- Chains carry/borrow through ADDC/SUBC and the shift SEL codes.
- Sits between the MCU control unit (or a wide-math peripheral) and an ALU instance that it does not contain.
- Returns the wide RESULT with aggregate C and Z flags under a START/BUSY/DONE handshake.

Parameters:
- NBYTES, 4, operand width in bytes (>=2); W = 8*NBYTES.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request pulse; sampled in IDLE or DONE.
- OP  in  3  operation, package encoding.
- CIN_EN  in  1  ADD/SUB only: first byte uses ADDC/SUBC with CIN.
- CIN  in  1  carry/borrow in; shift-in bit for LSL/LSR.
- A_W  in  W  operand A.
- B_W  in  W  operand B.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  W  wide result; held until next accepted START.
- C  out  1  final carry/borrow/shifted-out bit.
- Z  out  1  1 iff RESULT == 0.
- ALU_SEL  out  4  to ALU SEL.
- ALU_A  out  8  to ALU A.
- ALU_B  out  8  to ALU B.
- ALU_CIN  out  1  to ALU CIN.
- ALU_RESULT  in  8  from ALU (combinational).
- ALU_C  in  1  from ALU.
- ALU_Z  in  1  from ALU.

Behaviour:
- Reset: state IDLE; BUSY, DONE, C, Z = 0; RESULT = 0.
- ALU drive outputs are zero whenever the state is not RUN.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on START with a legal OP. START latches A_W, B_W, OP, CIN_EN and CIN, sets idx to its start value, and clears the internal carry register to 0.
- OP = 7 (reserved): START ignored, state unchanged.
- START while in RUN: ignored. Latched operands and idx are unaffected.
- RUN: one byte per cycle.
  - ALU_A = A byte idx; ALU_B = B byte idx.
  - ALU_SEL and ALU_CIN are combinational from the latched op, idx and the carry register.
  - Each edge: RESULT byte idx <= ALU_RESULT; carry register <= ALU_C; Z accumulator <= Z accumulator AND ALU_Z.
  - Z accumulator is seeded 1 on START.
- idx order:
  - LSR: NBYTES-1 down to 0.
  - All other ops: 0 up to NBYTES-1.
  - After the last byte: RUN -> DONE.
- SEL per op:
  - ADD: first byte SEL 0, or 1 if CIN_EN; later bytes SEL 1.
  - SUB: first byte SEL 2, or 3 if CIN_EN; later bytes SEL 3.
  - AND 5, OR 6, XOR 7: every byte, ALU_CIN = 0.
  - LSL 9 and LSR 10: every byte.
- ALU_CIN per op:
  - ADD/SUB first byte: CIN if CIN_EN, else 0.
  - ADD/SUB later bytes, and shifts after their first byte: carry register.
  - Shifts, first byte processed: CIN.
- DONE state lasts exactly one cycle.
  - Registered DONE=1; C = carry register (last ALU_C); Z = Z accumulator.
  - Then returns to IDLE, or to RUN if START is asserted that cycle.
  - C, Z and RESULT hold until the next accepted START.
- Latency: START at edge t gives BUSY=1 for edges t+1..t+NBYTES. DONE=1 is visible during the cycle following edge t+NBYTES, i.e. NBYTES+1 cycles after START.
- SUB borrow convention: C=1 means A < B (unsigned, including CIN).
- RST mid-RUN: abort, outputs to reset values, no DONE pulse.
- RESULT is updated byte-wise during RUN; consumers sample it only on DONE.

Decomposition:
- Package alu_seq_pkg:
  - ALU SEL constants: SEL_ADD=0, SEL_ADDC=1, SEL_SUB=2, SEL_SUBC=3, SEL_AND=5, SEL_OR=6, SEL_XOR=7, SEL_LSL=9, SEL_LSR=10.
  - op_t encoding: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_LSL=5, OP_LSR=6, 7 reserved.
  - state_t: IDLE, RUN, DONE.
- No sub-module. The ALU is instantiated beside this block by the parent and by the bench.

Test Plan (NBYTES=4, bench wires the team ALU to the ALU_* ports):
- ADD 0x00FFFFFF + 0x00000001, CIN_EN=0 -> ALU_SEL sequence 0,1,1,1; RESULT 0x01000000; C=0; Z=0; DONE exactly 5 cycles after START.
- ADD 0xFFFFFFFF + 0x00000001 -> RESULT 0x00000000, C=1, Z=1. SUB 0x00000000 - 0x00000001 -> SEL 2,3,3,3; RESULT 0xFFFFFFFF; C=1; Z=0.
- SUB with CIN_EN=1, CIN=1: 0x00000005 - 0x00000004 -> RESULT 0x00000000, C=0, Z=1.
- LSL 0x80000001 with CIN=1 -> RESULT 0x00000003, C=1. LSR 0x80000001 with CIN=0 -> bytes issued in order 3,2,1,0; RESULT 0x40000000; C=1.
- XOR A=B=0x12345678 -> RESULT 0, Z=1, C=0. OP=7 START -> BUSY stays 0 and no DONE.
- RST during the third RUN cycle -> next cycle BUSY=0, RESULT=0, no DONE. START pulsed while BUSY -> ignored, original result unchanged. START in the DONE cycle -> back-to-back run, BUSY the next cycle.
